// File: rtl/audio_pkg.sv
// audio_pkg: shared rate encodings and constants for the audio pacing path.
package audio_pkg;

    typedef enum logic [1:0] {
        RATE_32K  = 2'd0,
        RATE_44K1 = 2'd1,
        RATE_48K  = 2'd2,
        RATE_96K  = 2'd3
    } rate_sel_t;

    localparam int unsigned RATE_LUT [4] = '{32000, 44100, 48000, 96000};

    localparam int UNDERRUN_W = 16;

    // Sample rate in Hz for a given rate selection.
    function automatic int unsigned rate_hz(input rate_sel_t sel);
        return RATE_LUT[sel];
    endfunction

endpackage

// File: rtl/audio_pacer_sync_fifo.sv
// sync_fifo: single-clock frame FIFO; the head frame is read straight from
// the storage registers so a pushed frame is visible one cycle after its push.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards whatever is queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/audio_pacer.sv
// audio_pacer: releases buffered PCM frames at an exact long-term sample rate
// derived from the system clock by a fractional phase accumulator, and
// produces a matching ~50% duty audio clock for the HDMI core.
module audio_pacer
    import audio_pkg::*;
#(
    parameter int CLK_HZ     = 30_000_000,
    parameter int CHANNELS   = 2,
    parameter int BIT_WIDTH  = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [1:0]                        rate_sel,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [CHANNELS*BIT_WIDTH-1:0]     in_data,
    output logic                              sample_strobe,
    output logic [CHANNELS*BIT_WIDTH-1:0]     sample_word,
    output logic                              audio_clk,
    output logic [$clog2(FIFO_DEPTH):0]       fill_level,
    output logic [UNDERRUN_W-1:0]             underruns
);

    localparam int FRAME_W = CHANNELS * BIT_WIDTH;
    localparam int ACC_W   = $clog2(CLK_HZ) + 1;
    localparam int SUM_W   = ACC_W + 1;
    localparam logic [SUM_W-1:0] CLK_C  = SUM_W'(CLK_HZ);
    localparam logic [SUM_W-1:0] HALF_C = SUM_W'(CLK_HZ / 2);

    rate_sel_t          rate_q;
    logic [ACC_W-1:0]   acc;
    logic [SUM_W-1:0]   step;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   acc_next;
    logic               wrap;
    logic               rate_change;
    logic               strobe_now;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FRAME_W-1:0] fifo_head;

    assign step        = SUM_W'(rate_hz(rate_q));
    assign sum         = {1'b0, acc} + step;
    assign wrap        = (sum >= CLK_C);
    assign acc_next    = wrap ? (sum - CLK_C) : sum;
    assign rate_change = (rate_sel != rate_q);
    assign strobe_now  = wrap && !rate_change;
    assign fifo_push   = in_valid && in_ready;
    assign in_ready    = !fifo_full;

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (strobe_now),
        .wdata (in_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    // Phase accumulator, rate register, strobe and audio clock; a rate change restarts the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q        <= RATE_48K;
            acc           <= '0;
            sample_strobe <= 1'b0;
            audio_clk     <= 1'b0;
        end else if (rate_change) begin
            rate_q        <= rate_sel_t'(rate_sel);
            acc           <= '0;
            sample_strobe <= 1'b0;
            audio_clk     <= 1'b0;
        end else begin
            acc           <= acc_next[ACC_W-1:0];
            sample_strobe <= wrap;
            if (wrap) begin
                audio_clk <= 1'b1;
            end else if (acc_next >= HALF_C) begin
                audio_clk <= 1'b0;
            end
        end
    end

    // Output frame and underrun counter, both updated only on a strobe edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_word <= '0;
            underruns   <= '0;
        end else if (strobe_now) begin
            if (!fifo_empty) begin
                sample_word <= fifo_head;
            end else if (underruns != '1) begin
                underruns <= underruns + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_pacer.sv
// tb_audio_pacer: directed and random stimulus against a closed-form
// reference of strobe timing plus a queue model of the frame FIFO.
module tb_audio_pacer;

    localparam int CLK_HZ     = 30_000_000;
    localparam int CHANNELS   = 2;
    localparam int BIT_WIDTH  = 24;
    localparam int FIFO_DEPTH = 8;
    localparam int FW         = CHANNELS * BIT_WIDTH;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam longint unsigned CLK_L = CLK_HZ;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       rate_sel;
    logic             in_valid;
    logic             in_ready;
    logic [FW-1:0]    in_data;
    logic             sample_strobe;
    logic [FW-1:0]    sample_word;
    logic             audio_clk;
    logic [CNT_W-1:0] fill_level;
    logic [15:0]      underruns;

    audio_pacer #(
        .CLK_HZ     (CLK_HZ),
        .CHANNELS   (CHANNELS),
        .BIT_WIDTH  (BIT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rate_sel      (rate_sel),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .sample_strobe (sample_strobe),
        .sample_word   (sample_word),
        .audio_clk     (audio_clk),
        .fill_level    (fill_level),
        .underruns     (underruns)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;
    int strobe_log[$];

    longint unsigned rate_table [4] = '{32000, 44100, 48000, 96000};
    int              m_rate_q;
    longint unsigned m_k;
    logic            m_strobe;
    logic            m_aclk;
    logic [FW-1:0]   m_word;
    logic [15:0]     m_under;
    logic [FW-1:0]   m_queue[$];

    function automatic logic [FW-1:0] frame_of(input int n);
        return {CHANNELS{BIT_WIDTH'(n)}};
    endfunction

    function automatic int log_at(input int i);
        return (i < strobe_log.size()) ? strobe_log[i] : -1;
    endfunction

    // True when the coming edge will emit a strobe, judged from the model alone.
    function automatic bit model_strobe_next();
        longint unsigned r;
        if (reset || (int'(rate_sel) != m_rate_q)) return 1'b0;
        r = rate_table[m_rate_q];
        return (((m_k + 1) * r) / CLK_L) != ((m_k * r) / CLK_L);
    endfunction

    // Reference: strobe n of an epoch falls on the first cycle k with k*R >= n*CLK;
    // the audio clock is high from a strobe until the phase passes half a period.
    task automatic update_model();
        longint unsigned r;
        bit push_ok;
        if (reset) begin
            m_rate_q = 2;
            m_k      = 0;
            m_strobe = 1'b0;
            m_aclk   = 1'b0;
            m_word   = '0;
            m_under  = '0;
            m_queue.delete();
            return;
        end
        push_ok = in_valid && (m_queue.size() != FIFO_DEPTH);
        if (int'(rate_sel) != m_rate_q) begin
            m_rate_q = int'(rate_sel);
            m_k      = 0;
            m_strobe = 1'b0;
            m_aclk   = 1'b0;
        end else begin
            m_k      = m_k + 1;
            r        = rate_table[m_rate_q];
            m_strobe = ((m_k * r) / CLK_L) != (((m_k - 1) * r) / CLK_L);
            m_aclk   = (((m_k * r) / CLK_L) >= 1) && (((m_k * r) % CLK_L) < (CLK_L / 2));
        end
        if (m_strobe) begin
            if (m_queue.size() > 0) m_word = m_queue.pop_front();
            else if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
        end
        if (push_ok) m_queue.push_back(in_data);
    endtask

    task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic checkOutput();
        check_val("sample_strobe", 64'(sample_strobe), 64'(m_strobe));
        check_val("audio_clk",     64'(audio_clk),     64'(m_aclk));
        check_val("sample_word",   64'(sample_word),   64'(m_word));
        check_val("underruns",     64'(underruns),     64'(m_under));
        check_val("fill_level",    64'(fill_level),    64'(m_queue.size()));
        check_val("in_ready",      64'(in_ready),      64'(m_queue.size() != FIFO_DEPTH));
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        update_model();
        if (reset) cyc = 0;
        else cyc++;
        #1;
        if (sample_strobe === 1'b1) strobe_log.push_back(cyc);
        checkOutput();
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (n) applyStimulus();
        reset = 1'b0;
        strobe_log.delete();
    endtask

    task automatic wait_strobe(input int budget, input string tag);
        int steps;
        steps = 0;
        do begin
            applyStimulus();
            steps++;
        end while ((sample_strobe !== 1'b1) && (steps < budget));
        check_val(tag, 64'(sample_strobe), 64'd1);
    endtask

    initial begin
        int aclk_high;
        int prev;
        int guard;
        longint unsigned exp_cyc;

        reset    = 1'b1;
        rate_sel = 2'd2;
        in_valid = 1'b0;
        in_data  = '0;
        m_rate_q = 2;
        m_k      = 0;
        m_strobe = 1'b0;
        m_aclk   = 1'b0;
        m_word   = '0;
        m_under  = '0;

        $display("[TB] reset state");
        do_reset(3);
        check_val("rst_fill",   64'(fill_level),    64'd0);
        check_val("rst_ready",  64'(in_ready),      64'd1);
        check_val("rst_strobe", 64'(sample_strobe), 64'd0);
        check_val("rst_aclk",   64'(audio_clk),     64'd0);
        check_val("rst_word",   64'(sample_word),   64'd0);
        check_val("rst_under",  64'(underruns),     64'd0);

        $display("[TB] 48 kHz spacing");
        aclk_high = 0;
        for (int i = 0; i < 1875; i++) begin
            applyStimulus();
            if (cyc >= 625 && cyc < 1250 && audio_clk === 1'b1) aclk_high++;
        end
        check_val("48k_count",   64'(strobe_log.size()), 64'd3);
        check_val("48k_strobe1", 64'(log_at(0)), 64'd625);
        check_val("48k_strobe2", 64'(log_at(1)), 64'd1250);
        check_val("48k_strobe3", 64'(log_at(2)), 64'd1875);
        check_val("48k_aclk_high", 64'(aclk_high), 64'd313);
        check_val("48k_underruns", 64'(underruns), 64'd3);

        $display("[TB] rate change mid-period");
        do_reset(2);
        repeat (299) applyStimulus();
        rate_sel = 2'd3;
        applyStimulus();
        check_val("rc_no_strobe", 64'(sample_strobe), 64'd0);
        check_val("rc_aclk",      64'(audio_clk),     64'd0);
        strobe_log.delete();
        repeat (313) applyStimulus();
        check_val("rc_next_count",  64'(strobe_log.size()), 64'd1);
        check_val("rc_next_strobe", 64'(log_at(0)), 64'd613);

        $display("[TB] rate change on the wrap cycle");
        rate_sel = 2'd2;
        do_reset(2);
        repeat (624) applyStimulus();
        rate_sel = 2'd3;
        applyStimulus();
        check_val("rcw_no_strobe", 64'(sample_strobe), 64'd0);
        check_val("rcw_under",     64'(underruns),     64'd0);

        $display("[TB] FIFO order and backpressure");
        do_reset(2);
        for (int n = 1; n <= 8; n++) begin
            in_valid = 1'b1;
            in_data  = frame_of(n);
            applyStimulus();
        end
        check_val("bp_fill",  64'(fill_level), 64'd8);
        check_val("bp_ready", 64'(in_ready),   64'd0);
        in_data = frame_of(9);
        repeat (5) applyStimulus();
        in_valid = 1'b0;
        check_val("bp_fill_held", 64'(fill_level), 64'd8);
        for (int n = 1; n <= 8; n++) begin
            wait_strobe(1000, "order_strobe");
            check_val("order_word", 64'(sample_word), 64'(frame_of(n)));
            if (n == 1) begin
                check_val("ready_after_pop", 64'(in_ready),   64'd1);
                check_val("fill_after_pop",  64'(fill_level), 64'd7);
            end
        end

        $display("[TB] underrun hold and saturation");
        do_reset(2);
        in_valid = 1'b1;
        in_data  = {CHANNELS{24'hABCDEF}};
        applyStimulus();
        in_valid = 1'b0;
        wait_strobe(400, "abc_strobe");
        check_val("abc_word", 64'(sample_word), 64'({CHANNELS{24'hABCDEF}}));
        repeat (3) wait_strobe(400, "ur_strobe");
        check_val("ur_word_held", 64'(sample_word), 64'({CHANNELS{24'hABCDEF}}));
        check_val("ur_count",     64'(underruns),   64'd3);
        force dut.underruns = 16'hFFFE;
        m_under = 16'hFFFE;
        applyStimulus();
        release dut.underruns;
        check_val("sat_preload", 64'(underruns), 64'hFFFE);
        repeat (3) wait_strobe(400, "sat_strobe");
        check_val("sat_count", 64'(underruns), 64'hFFFF);

        $display("[TB] push on an empty-FIFO strobe");
        do_reset(2);
        guard = 0;
        while (!model_strobe_next() && guard < 1000) begin
            applyStimulus();
            guard++;
        end
        in_valid = 1'b1;
        in_data  = {CHANNELS{24'h123456}};
        applyStimulus();
        in_valid = 1'b0;
        check_val("sim_strobe", 64'(sample_strobe), 64'd1);
        check_val("sim_under",  64'(underruns),     64'd1);
        check_val("sim_fill",   64'(fill_level),    64'd1);
        wait_strobe(400, "sim_pop_strobe");
        check_val("sim_pop_word", 64'(sample_word), 64'({CHANNELS{24'h123456}}));

        $display("[TB] reset with frames queued");
        for (int n = 11; n <= 15; n++) begin
            in_valid = 1'b1;
            in_data  = frame_of(n);
            applyStimulus();
        end
        in_valid = 1'b0;
        check_val("q5_fill", 64'(fill_level), 64'd5);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        check_val("mid_rst_fill",  64'(fill_level),  64'd0);
        check_val("mid_rst_word",  64'(sample_word), 64'd0);
        check_val("mid_rst_under", 64'(underruns),   64'd0);
        check_val("mid_rst_ready", 64'(in_ready),    64'd1);

        $display("[TB] 44.1 kHz fractional spacing");
        rate_sel = 2'd1;
        do_reset(2);
        applyStimulus();
        prev = cyc;
        for (int n = 1; n <= 15; n++) begin
            wait_strobe(800, "44k1_strobe");
            exp_cyc = (longint'(n) * CLK_L + 44099) / 44100;
            check_val("44k1_time", 64'(cyc - 1), exp_cyc);
            if (n > 1) check_val("44k1_gap", 64'((cyc - prev) == 680 || (cyc - prev) == 681), 64'd1);
            prev = cyc;
        end

        $display("[TB] random traffic");
        rate_sel = 2'd3;
        do_reset(2);
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 2999) == 0) rate_sel = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 249) == 0);
            in_data  = FW'({$urandom(), $urandom()});
            reset    = ($urandom_range(0, 7999) == 0);
            applyStimulus();
        end
        reset    = 1'b0;
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
